// File: rtl/alu_reservation_station_if.sv
// rtl/alu_reservation_station_if.sv - dispatch, wakeup, kill and issue signals of the ALU reservation station
interface alu_reservation_station_if #(
   parameter int ENTRY_SEL    = 3,
   parameter int DATA_LEN     = 32,
   parameter int RRF_TAG_LEN  = 6,
   parameter int ALU_OP_WIDTH = 4
);
   // dispatch from rename
   logic                    dp_valid_i;
   logic                    dp_ready_o;
   logic [ALU_OP_WIDTH-1:0] dp_alu_op_i;
   logic [DATA_LEN-1:0]     dp_src1_i;
   logic                    dp_src1_valid_i;
   logic [DATA_LEN-1:0]     dp_src2_i;
   logic                    dp_src2_valid_i;
   logic [RRF_TAG_LEN-1:0]  dp_rrf_tag_i;
   logic                    dp_write_rrf_i;
   // writeback broadcast
   logic                    wb_valid_i;
   logic [RRF_TAG_LEN-1:0]  wb_tag_i;
   logic [DATA_LEN-1:0]     wb_data_i;
   // flush
   logic                    kill_i;
   // issue to the ALU
   logic                    issue_o;
   logic [ALU_OP_WIDTH-1:0] alu_op_o;
   logic [DATA_LEN-1:0]     src1_o;
   logic [DATA_LEN-1:0]     src2_o;
   logic                    write_rrf_o;
   logic [RRF_TAG_LEN-1:0]  rrf_tag_o;
   logic [ENTRY_SEL:0]      busy_count_o;

   modport slave (
      input  dp_valid_i, dp_alu_op_i, dp_src1_i, dp_src1_valid_i, dp_src2_i,
             dp_src2_valid_i, dp_rrf_tag_i, dp_write_rrf_i,
             wb_valid_i, wb_tag_i, wb_data_i, kill_i,
      output dp_ready_o, issue_o, alu_op_o, src1_o, src2_o, write_rrf_o,
             rrf_tag_o, busy_count_o
   );

   modport master (
      output dp_valid_i, dp_alu_op_i, dp_src1_i, dp_src1_valid_i, dp_src2_i,
             dp_src2_valid_i, dp_rrf_tag_i, dp_write_rrf_i,
             wb_valid_i, wb_tag_i, wb_data_i, kill_i,
      input  dp_ready_o, issue_o, alu_op_o, src1_o, src2_o, write_rrf_o,
             rrf_tag_o, busy_count_o
   );
endinterface

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - buffers dispatched ALU ops, wakes operands from writeback, issues one ready op per cycle
module alu_reservation_station #(
   parameter int ENTRY_NUM    = 8,
   parameter int ENTRY_SEL    = 3,
   parameter int DATA_LEN     = 32,
   parameter int RRF_TAG_LEN  = 6,
   parameter int ALU_OP_WIDTH = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   alu_reservation_station_if.slave  rs
);

   logic [ENTRY_NUM-1:0]    ent_valid;
   logic [ENTRY_NUM-1:0]    ent_src1_valid;
   logic [ENTRY_NUM-1:0]    ent_src2_valid;
   logic [ENTRY_NUM-1:0]    ent_write_rrf;
   logic [ALU_OP_WIDTH-1:0] ent_op   [ENTRY_NUM];
   logic [DATA_LEN-1:0]     ent_src1 [ENTRY_NUM];
   logic [DATA_LEN-1:0]     ent_src2 [ENTRY_NUM];
   logic [RRF_TAG_LEN-1:0]  ent_tag  [ENTRY_NUM];

   logic [ENTRY_NUM-1:0]    ent_ready;
   logic                    free_found;
   logic [ENTRY_SEL-1:0]    free_idx;
   logic                    sel_found;
   logic [ENTRY_SEL-1:0]    sel_idx;
   logic                    dp_accept;

   logic                    src1_bypass;
   logic                    src2_bypass;
   logic [DATA_LEN-1:0]     dp_src1_val;
   logic [DATA_LEN-1:0]     dp_src2_val;

   logic                    issue_r;
   logic [ALU_OP_WIDTH-1:0] alu_op_r;
   logic [DATA_LEN-1:0]     src1_r;
   logic [DATA_LEN-1:0]     src2_r;
   logic                    write_rrf_r;
   logic [RRF_TAG_LEN-1:0]  rrf_tag_r;
   logic [ENTRY_SEL:0]      busy_count;

   assign ent_ready = ent_valid & ent_src1_valid & ent_src2_valid;

   // Lowest-index free slot for allocation and lowest-index ready slot for issue
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      sel_found  = 1'b0;
      sel_idx    = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (!ent_valid[i]) begin
            free_found = 1'b1;
            free_idx   = ENTRY_SEL'(i);
         end
         if (ent_ready[i]) begin
            sel_found = 1'b1;
            sel_idx   = ENTRY_SEL'(i);
         end
      end
   end

   // Dispatch readiness comes only from registered valid bits, so a slot freed by
   // this cycle's issue is not offered until the next cycle.
   assign dp_accept = rs.dp_valid_i & free_found;

   // Same-cycle bypass: a dispatching operand waiting on the tag now broadcast is stored as a value
   assign src1_bypass = !rs.dp_src1_valid_i && rs.wb_valid_i &&
                        (rs.dp_src1_i[RRF_TAG_LEN-1:0] == rs.wb_tag_i);
   assign src2_bypass = !rs.dp_src2_valid_i && rs.wb_valid_i &&
                        (rs.dp_src2_i[RRF_TAG_LEN-1:0] == rs.wb_tag_i);
   assign dp_src1_val = src1_bypass ? rs.wb_data_i : rs.dp_src1_i;
   assign dp_src2_val = src2_bypass ? rs.wb_data_i : rs.dp_src2_i;

   // Entry storage: wakeup capture, release of the issued slot, allocation of the free slot
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         ent_valid      <= '0;
         ent_src1_valid <= '0;
         ent_src2_valid <= '0;
         ent_write_rrf  <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            ent_op[i]   <= '0;
            ent_src1[i] <= '0;
            ent_src2[i] <= '0;
            ent_tag[i]  <= '0;
         end
      end else if (rs.kill_i) begin
         ent_valid <= '0;
      end else begin
         for (int i = 0; i < ENTRY_NUM; i++) begin
            if (ent_valid[i] && !ent_src1_valid[i] && rs.wb_valid_i &&
                ent_src1[i][RRF_TAG_LEN-1:0] == rs.wb_tag_i) begin
               ent_src1[i]       <= rs.wb_data_i;
               ent_src1_valid[i] <= 1'b1;
            end
            if (ent_valid[i] && !ent_src2_valid[i] && rs.wb_valid_i &&
                ent_src2[i][RRF_TAG_LEN-1:0] == rs.wb_tag_i) begin
               ent_src2[i]       <= rs.wb_data_i;
               ent_src2_valid[i] <= 1'b1;
            end
         end
         if (sel_found) begin
            ent_valid[sel_idx] <= 1'b0;
         end
         if (dp_accept) begin
            ent_valid[free_idx]      <= 1'b1;
            ent_op[free_idx]         <= rs.dp_alu_op_i;
            ent_src1[free_idx]       <= dp_src1_val;
            ent_src1_valid[free_idx] <= rs.dp_src1_valid_i | src1_bypass;
            ent_src2[free_idx]       <= dp_src2_val;
            ent_src2_valid[free_idx] <= rs.dp_src2_valid_i | src2_bypass;
            ent_tag[free_idx]        <= rs.dp_rrf_tag_i;
            ent_write_rrf[free_idx]  <= rs.dp_write_rrf_i;
         end
      end
   end

   // Issue register: selected entry's fields are latched; data holds when nothing issues
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         issue_r     <= 1'b0;
         alu_op_r    <= '0;
         src1_r      <= '0;
         src2_r      <= '0;
         write_rrf_r <= 1'b0;
         rrf_tag_r   <= '0;
      end else if (rs.kill_i) begin
         issue_r     <= 1'b0;
         alu_op_r    <= '0;
         src1_r      <= '0;
         src2_r      <= '0;
         write_rrf_r <= 1'b0;
         rrf_tag_r   <= '0;
      end else begin
         issue_r <= sel_found;
         if (sel_found) begin
            alu_op_r    <= ent_op[sel_idx];
            src1_r      <= ent_src1[sel_idx];
            src2_r      <= ent_src2[sel_idx];
            write_rrf_r <= ent_write_rrf[sel_idx];
            rrf_tag_r   <= ent_tag[sel_idx];
         end
      end
   end

   // Occupancy counter: dispatch adds one, issue removes one
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         busy_count <= '0;
      end else if (rs.kill_i) begin
         busy_count <= '0;
      end else if (dp_accept && !sel_found) begin
         busy_count <= busy_count + (ENTRY_SEL + 1)'(1);
      end else if (!dp_accept && sel_found) begin
         busy_count <= busy_count - (ENTRY_SEL + 1)'(1);
      end
   end

   assign rs.dp_ready_o   = free_found;
   assign rs.issue_o      = issue_r;
   assign rs.alu_op_o     = alu_op_r;
   assign rs.src1_o       = src1_r;
   assign rs.src2_o       = src2_r;
   assign rs.write_rrf_o  = write_rrf_r;
   assign rs.rrf_tag_o    = rrf_tag_r;
   assign rs.busy_count_o = busy_count;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - self-checking bench for alu_reservation_station
module tb_alu_reservation_station;

   localparam int N = 8;
   localparam bit [3:0] OP_ADD = 4'h1;
   localparam bit [3:0] OP_SUB = 4'h2;

   logic clk;
   logic reset_i;
   int   tests = 0;
   int   fails = 0;

   alu_reservation_station_if #(.ENTRY_SEL(3), .DATA_LEN(32), .RRF_TAG_LEN(6), .ALU_OP_WIDTH(4)) rs_if ();

   alu_reservation_station #(
      .ENTRY_NUM(N), .ENTRY_SEL(3), .DATA_LEN(32), .RRF_TAG_LEN(6), .ALU_OP_WIDTH(4)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .rs      (rs_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        v;
      bit [3:0]  op;
      bit [31:0] s1;
      bit        s1v;
      bit [31:0] s2;
      bit        s2v;
      bit [5:0]  tag;
      bit        wr;
   } slot_t;

   slot_t     m_slot [N];
   bit        e_issue = 1'b0;
   bit [3:0]  e_op    = '0;
   bit [31:0] e_s1    = '0;
   bit [31:0] e_s2    = '0;
   bit [5:0]  e_tag   = '0;
   bit        e_wr    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_busy();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_slot[i].v) c++;
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_slot[i] = '{default: 0};
      e_issue = 0; e_op = 0; e_s1 = 0; e_s2 = 0; e_tag = 0; e_wr = 0;
   endtask

   // Reference behaviour for one clock edge, evaluated on the inputs present at that edge
   task automatic model_step();
      int    sel;
      int    fr;
      slot_t d;
      if (!reset_i || rs_if.kill_i) begin
         model_reset();
         return;
      end
      sel = -1;
      fr  = -1;
      for (int i = 0; i < N; i++) begin
         if (sel < 0 && m_slot[i].v && m_slot[i].s1v && m_slot[i].s2v) sel = i;
         if (fr < 0 && !m_slot[i].v) fr = i;
      end
      for (int i = 0; i < N; i++) begin
         if (m_slot[i].v && rs_if.wb_valid_i) begin
            if (!m_slot[i].s1v && m_slot[i].s1[5:0] == rs_if.wb_tag_i) begin
               m_slot[i].s1 = rs_if.wb_data_i; m_slot[i].s1v = 1;
            end
            if (!m_slot[i].s2v && m_slot[i].s2[5:0] == rs_if.wb_tag_i) begin
               m_slot[i].s2 = rs_if.wb_data_i; m_slot[i].s2v = 1;
            end
         end
      end
      e_issue = (sel >= 0);
      if (sel >= 0) begin
         e_op = m_slot[sel].op; e_s1 = m_slot[sel].s1; e_s2 = m_slot[sel].s2;
         e_tag = m_slot[sel].tag; e_wr = m_slot[sel].wr;
         m_slot[sel].v = 0;
      end
      if (rs_if.dp_valid_i && fr >= 0) begin
         d.v = 1; d.op = rs_if.dp_alu_op_i; d.tag = rs_if.dp_rrf_tag_i; d.wr = rs_if.dp_write_rrf_i;
         d.s1 = rs_if.dp_src1_i; d.s1v = rs_if.dp_src1_valid_i;
         d.s2 = rs_if.dp_src2_i; d.s2v = rs_if.dp_src2_valid_i;
         if (!d.s1v && rs_if.wb_valid_i && d.s1[5:0] == rs_if.wb_tag_i) begin
            d.s1 = rs_if.wb_data_i; d.s1v = 1;
         end
         if (!d.s2v && rs_if.wb_valid_i && d.s2[5:0] == rs_if.wb_tag_i) begin
            d.s2 = rs_if.wb_data_i; d.s2v = 1;
         end
         m_slot[fr] = d;
      end
   endtask

   // Every cycle: DUT outputs against the reference
   always @(negedge clk) begin
      check("issue_o", rs_if.issue_o, e_issue);
      check("alu_op_o", rs_if.alu_op_o, e_op);
      check("src1_o", rs_if.src1_o, e_s1);
      check("src2_o", rs_if.src2_o, e_s2);
      check("rrf_tag_o", rs_if.rrf_tag_o, e_tag);
      check("write_rrf_o", rs_if.write_rrf_o, e_wr);
      check("busy_count_o", rs_if.busy_count_o, m_busy());
      check("dp_ready_o", rs_if.dp_ready_o, m_busy() < N);
   end

   task automatic idle();
      rs_if.dp_valid_i = 0; rs_if.dp_alu_op_i = 0;
      rs_if.dp_src1_i = 0; rs_if.dp_src1_valid_i = 0;
      rs_if.dp_src2_i = 0; rs_if.dp_src2_valid_i = 0;
      rs_if.dp_rrf_tag_i = 0; rs_if.dp_write_rrf_i = 0;
      rs_if.wb_valid_i = 0; rs_if.wb_tag_i = 0; rs_if.wb_data_i = 0;
      rs_if.kill_i = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic dispatch(input bit [3:0] op, input bit [31:0] s1, input bit s1v,
                           input bit [31:0] s2, input bit s2v, input bit [5:0] tag, input bit wr);
      rs_if.dp_valid_i = 1; rs_if.dp_alu_op_i = op;
      rs_if.dp_src1_i = s1; rs_if.dp_src1_valid_i = s1v;
      rs_if.dp_src2_i = s2; rs_if.dp_src2_valid_i = s2v;
      rs_if.dp_rrf_tag_i = tag; rs_if.dp_write_rrf_i = wr;
   endtask

   task automatic broadcast(input bit [5:0] tag, input bit [31:0] data);
      rs_if.wb_valid_i = 1; rs_if.wb_tag_i = tag; rs_if.wb_data_i = data;
   endtask

   initial begin
      int pulses;
      reset_i = 1'b0;
      idle();
      repeat (3) tick();
      reset_i = 1'b1;
      tick();
      check("rst_issue", rs_if.issue_o, 0);
      check("rst_busy", rs_if.busy_count_o, 0);
      check("rst_ready", rs_if.dp_ready_o, 1);

      // 1: both operands ready
      dispatch(OP_ADD, 10, 1, 12, 1, 5, 1);
      tick(); idle();
      check("t1_busy_held", rs_if.busy_count_o, 1);
      tick();
      check("t1_issue", rs_if.issue_o, 1);
      check("t1_op", rs_if.alu_op_o, OP_ADD);
      check("t1_src1", rs_if.src1_o, 10);
      check("t1_src2", rs_if.src2_o, 12);
      check("t1_tag", rs_if.rrf_tag_o, 5);
      check("t1_wr", rs_if.write_rrf_o, 1);
      tick();
      check("t1_issue_end", rs_if.issue_o, 0);
      check("t1_busy_end", rs_if.busy_count_o, 0);

      // 2: src2 waits on tag 7
      dispatch(OP_SUB, 3, 1, 7, 0, 9, 0);
      tick(); idle();
      repeat (2) begin
         tick();
         check("t2_wait", rs_if.issue_o, 0);
      end
      broadcast(7, 32'h55);
      tick(); idle();
      check("t2_wake_edge", rs_if.issue_o, 0);
      tick();
      check("t2_issue", rs_if.issue_o, 1);
      check("t2_src2", rs_if.src2_o, 32'h55);
      check("t2_tag", rs_if.rrf_tag_o, 9);

      // 3: bypass on dispatch
      dispatch(4'h3, 3, 0, 4, 1, 11, 1);
      broadcast(3, 9);
      tick(); idle();
      tick();
      check("t3_issue", rs_if.issue_o, 1);
      check("t3_src1", rs_if.src1_o, 9);
      check("t3_tag", rs_if.rrf_tag_o, 11);

      // 4: fill, full, drain in index order
      for (int k = 0; k < N; k++) begin
         dispatch(OP_ADD, 1, 0, k, 1, 6'(16 + k), 1);
         tick();
      end
      idle();
      check("t4_busy_full", rs_if.busy_count_o, 8);
      check("t4_ready_full", rs_if.dp_ready_o, 0);
      dispatch(OP_SUB, 0, 1, 0, 1, 40, 1);
      tick(); idle();
      check("t4_busy_ignored", rs_if.busy_count_o, 8);
      broadcast(1, 32'h100);
      tick(); idle();
      for (int k = 0; k < N; k++) begin
         tick();
         check("t4_issue", rs_if.issue_o, 1);
         check("t4_order_tag", rs_if.rrf_tag_o, 16 + k);
         check("t4_src1", rs_if.src1_o, 32'h100);
         check("t4_busy", rs_if.busy_count_o, 7 - k);
      end
      tick();
      check("t4_idle", rs_if.issue_o, 0);

      // 5: kill
      for (int k = 0; k < 4; k++) begin
         dispatch(OP_ADD, 6, 1, 2, 0, 6'(k), 0);
         tick();
      end
      idle();
      rs_if.kill_i = 1;
      tick(); idle();
      check("t5_busy", rs_if.busy_count_o, 0);
      check("t5_ready", rs_if.dp_ready_o, 1);
      check("t5_src1_clr", rs_if.src1_o, 0);
      broadcast(2, 32'h77);
      tick(); idle();
      pulses = 0;
      repeat (3) begin
         tick();
         if (rs_if.issue_o) pulses++;
      end
      check("t5_no_issue", pulses, 0);

      // 6: asynchronous reset with entries held
      dispatch(4'h5, 32'hAA, 1, 32'hBB, 1, 33, 1);
      tick();
      for (int k = 0; k < 3; k++) begin
         dispatch(OP_SUB, 4, 0, 1, 1, 6'(20 + k), 1);
         tick();
      end
      idle();
      tick();
      check("t6_busy_held", rs_if.busy_count_o, 3);
      check("t6_src1_before", rs_if.src1_o, 32'hAA);
      @(posedge clk);
      #2 reset_i = 1'b0;
      model_reset();
      #1;
      check("t6_busy", rs_if.busy_count_o, 0);
      check("t6_ready", rs_if.dp_ready_o, 1);
      check("t6_issue", rs_if.issue_o, 0);
      check("t6_src1", rs_if.src1_o, 0);
      check("t6_src2", rs_if.src2_o, 0);
      check("t6_tag", rs_if.rrf_tag_o, 0);
      @(negedge clk);
      tick();
      reset_i = 1'b1;
      broadcast(4, 32'h99);
      tick(); idle();
      pulses = 0;
      repeat (3) begin
         tick();
         if (rs_if.issue_o) pulses++;
      end
      check("t6_discarded", pulses, 0);
      dispatch(4'h6, 1, 1, 2, 1, 7, 1);
      tick(); idle();
      tick();
      check("t6_recover_issue", rs_if.issue_o, 1);
      check("t6_recover_tag", rs_if.rrf_tag_o, 7);
      tick();

      #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
